// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down counter whose state is held in a
// bank of JK cells (one jk_ff per bit). The next value is computed in binary.
// Minimal J/K excitation is then derived from it, so that no cell ever sees
// J=K=1. The J/K vectors are exported so the excitation can be observed.

// Single JK cell. Its synchronous clear gives a known state from power-up X.
// With a pure JK update, K=X would hold X forever in a 4-state simulator.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  logic q_q;
  logic q_d;

  // Standard JK characteristic equation.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap
);
  // MODULUS may equal 2**WIDTH, so compare against it with one extra bit.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;
  logic             wrap_d;

  // The next binary value, in priority order: reset, load, count, hold.
  always_comb begin
    at_max  = (count == MAX_C);
    at_zero = (count == '0);
    nxt     = count;
    if (rst) begin
      nxt = '0;
    end else if (load) begin
      nxt = ({1'b0, din} < MOD_W) ? din : MAX_C;
    end else if (en) begin
      if (up) nxt = at_max  ? '0    : count + WIDTH'(1);
      else    nxt = at_zero ? MAX_C : count - WIDTH'(1);
    end
  end

  // Minimal excitation. Set only the bits that rise, and clear only the bits that fall.
  always_comb begin
    j_vec = ~count & nxt;
    k_vec = count & ~nxt;
  end

  // Terminal count is asserted when this edge wraps. It ignores rst by design.
  always_comb begin
    tc     = en & ~load & ((up & at_max) | (~up & at_zero));
    wrap_d = tc & ~rst;
  end

  // Cell bank: each bit updates only from its own J/K pair.
  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_ff u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[b]),
      .k   (k_vec[b]),
      .q   (count[b])
    );
  end

  // One-cycle wrap pulse that follows each wrapping edge.
  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
endmodule
